// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the multicycle datapath.
// Carries the opcode, flag and memory handshake inputs, and all mux selects and strobes.
// The master modport is the controller side. The slave modport is the datapath side.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             adr_src;
  logic             ir_write;
  logic             pc_write;
  logic             mem_write;
  logic             reg_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       imm_src;
  logic [CNT_W-1:0] instret;
  logic             illegal_op;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, instret, illegal_op
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, instret, illegal_op
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM (fetch/decode/execute/memory/writeback) with a retired-instruction counter.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles. Outputs are registered from the state; ir_write/pc_write also gate on mem_ready/zero.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready. CTRL_ILLEGAL_OP_EN adds a sticky ILLEGAL trap state.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
`ifdef CTRL_ILLEGAL_OP_EN
    , ILLEGAL
`endif
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_en;      // ir_write, qualified by mem_ready
    logic       fetch_pc;   // PC+4 update in FETCH, qualified by mem_ready
    logic       mem_write;
    logic       reg_write;
    logic       pc_update;  // unconditional PC load (jal)
    logic       branch;     // PC load qualified by zero
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Per-state control word; every field not named stays 0.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req = 1'b1; c.ir_en = 1'b1; c.fetch_pc = 1'b1;
        c.alu_src_b = 2'b10; c.result_src = 2'b10;
      end
      DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      MEMWRITE: begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECUTER: begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      EXECUTEI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      ALUWB:    c.reg_write = 1'b1;
      BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
      default:  c = '0;  // ILLEGAL: everything low
    endcase
    return c;
  endfunction

  state_t           state_q, state_nxt;
  ctrl_t            ctrl_q;
  logic             retire;
  logic [CNT_W-1:0] instret_q;

  // Next state and retirement detection from the current state, opcode and memory handshake.
  always_comb begin
    state_nxt = state_q;
    retire    = 1'b0;
    case (state_q)
      FETCH:  if (bus.mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_R:         state_nxt = EXECUTER;
          OP_I:         state_nxt = EXECUTEI;
          OP_BEQ:       state_nxt = BEQ;
          OP_JAL:       state_nxt = JAL;
`ifdef CTRL_ILLEGAL_OP_EN
          default:      state_nxt = ILLEGAL;
`else
          default:      state_nxt = FETCH;  // no-op, not counted as retired
`endif
        endcase
      end
      MEMADR:   state_nxt = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (bus.mem_ready) state_nxt = MEMWB;
      MEMWRITE: if (bus.mem_ready) begin state_nxt = FETCH; retire = 1'b1; end
      MEMWB, ALUWB, BEQ: begin state_nxt = FETCH; retire = 1'b1; end
      EXECUTER, EXECUTEI, JAL: state_nxt = ALUWB;
      default:  state_nxt = state_q;  // ILLEGAL holds until reset
    endcase
  end

  // State register, registered control word, retired counter and sticky illegal flag.
`ifdef CTRL_ILLEGAL_OP_EN
  logic illegal_q;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      ctrl_q    <= decode(FETCH);
      instret_q <= '0;
`ifdef CTRL_ILLEGAL_OP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= decode(state_nxt);
      if (retire) instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef CTRL_ILLEGAL_OP_EN
      if (state_nxt == ILLEGAL) illegal_q <= 1'b1;
`endif
    end
  end

`ifdef CTRL_ILLEGAL_OP_EN
  assign bus.illegal_op = illegal_q;
`else
  assign bus.illegal_op = 1'b0;
`endif

  // Strobes are forced low during reset so an aborted instruction commits nothing.
  assign bus.mem_req    = ctrl_q.mem_req   & ~reset;
  assign bus.mem_write  = ctrl_q.mem_write & ~reset;
  assign bus.reg_write  = ctrl_q.reg_write & ~reset;
  assign bus.ir_write   = ctrl_q.ir_en & bus.mem_ready & ~reset;
  assign bus.pc_write   = ~reset & ((ctrl_q.fetch_pc & bus.mem_ready) | ctrl_q.pc_update
                                    | (ctrl_q.branch & bus.zero));
  assign bus.adr_src    = ctrl_q.adr_src;
  assign bus.result_src = ctrl_q.result_src;
  assign bus.alu_src_a  = ctrl_q.alu_src_a;
  assign bus.alu_src_b  = ctrl_q.alu_src_b;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.instret    = instret_q;

  // Immediate format straight from the opcode.
  always_comb begin
    case (bus.op)
      OP_SW:   bus.imm_src = 2'b01;
      OP_BEQ:  bus.imm_src = 2'b10;
      OP_JAL:  bus.imm_src = 2'b11;
      default: bus.imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle strobe/select checks for each instruction class.
// Inputs change on the falling edge; outputs are sampled 1 ns later, away from the rising edge.
// A second instance with CNT_W=4 shares the inputs to check counter wrap.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails = 0;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  multicycle_controller_if #(.CNT_W(32)) bus ();
  multicycle_controller_if #(.CNT_W(4))  bus4 ();

  multicycle_controller #(.CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
  multicycle_controller #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  assign bus4.op        = bus.op;
  assign bus4.zero      = bus.zero;
  assign bus4.mem_ready = bus.mem_ready;

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.op = OP_R; bus.zero = 1'b1; bus.mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({bus.mem_req, bus.ir_write, bus.pc_write, bus.mem_write, bus.reg_write} !== 5'b0) begin
      fails++; $display("FAIL reset_strobes got %b want 00000",
        {bus.mem_req, bus.ir_write, bus.pc_write, bus.mem_write, bus.reg_write});
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if ({bus.mem_req, bus.ir_write, bus.adr_src, bus.alu_src_b, bus.result_src} !== 7'b1101010) begin
      fails++; $display("FAIL reset_fetch got %b want 1101010",
        {bus.mem_req, bus.ir_write, bus.adr_src, bus.alu_src_b, bus.result_src});
    end
    checks++;
    if (bus.instret !== 32'd0 || bus.illegal_op !== 1'b0) begin
      fails++; $display("FAIL reset_cnt got instret=%0d illegal=%b want 0/0", bus.instret, bus.illegal_op);
    end
  endtask

  // R-type, no stalls: FETCH DECODE EXECUTER ALUWB.
  task automatic test_rtype();
    logic [3:0] exp_ir, exp_rw, exp_rq;
    logic [7:0] exp_a, exp_op;
    exp_ir = 4'b1000; exp_rw = 4'b0001; exp_rq = 4'b1000;
    exp_a = 8'b00_01_10_00; exp_op = 8'b00_00_10_00;
    do_reset();
    bus.op = OP_R; bus.mem_ready = 1'b1; bus.zero = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({bus.ir_write, bus.reg_write, bus.mem_req, bus.alu_src_a, bus.alu_op} !==
          {exp_ir[3-c], exp_rw[3-c], exp_rq[3-c], exp_a[7-2*c -: 2], exp_op[7-2*c -: 2]}) begin
        fails++; $display("FAIL rtype_cycle%0d got %b want %b", c + 1,
          {bus.ir_write, bus.reg_write, bus.mem_req, bus.alu_src_a, bus.alu_op},
          {exp_ir[3-c], exp_rw[3-c], exp_rq[3-c], exp_a[7-2*c -: 2], exp_op[7-2*c -: 2]});
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (bus.instret !== 32'd1 || bus.mem_req !== 1'b1) begin
      fails++; $display("FAIL rtype_retire got instret=%0d mem_req=%b want 1/1", bus.instret, bus.mem_req);
    end
  endtask

  // lw with 2 FETCH waits and 3 MEMREAD waits: 10 cycles.
  task automatic test_lw_stall();
    logic [9:0] rdy, e_ir, e_rw, e_adr;
    int rw_cnt;
    rdy   = 10'b0011100011;
    e_ir  = 10'b0010000000;
    e_rw  = 10'b0000000001;
    e_adr = 10'b0000011110;
    rw_cnt = 0;
    do_reset();
    bus.op = OP_LW;
    for (int c = 0; c < 10; c++) begin
      bus.mem_ready = rdy[9-c];
      #1;
      if (bus.reg_write) rw_cnt++;
      checks++;
      if ({bus.ir_write, bus.reg_write, bus.adr_src} !== {e_ir[9-c], e_rw[9-c], e_adr[9-c]}) begin
        fails++; $display("FAIL lw_cycle%0d got %b want %b", c + 1,
          {bus.ir_write, bus.reg_write, bus.adr_src}, {e_ir[9-c], e_rw[9-c], e_adr[9-c]});
      end
      @(negedge clk);
    end
    bus.mem_ready = 1'b0; #1;
    checks++;
    if (rw_cnt != 1 || bus.instret !== 32'd1 || bus.mem_req !== 1'b1 || bus.adr_src !== 1'b0
        || bus.imm_src !== 2'b00) begin
      fails++; $display("FAIL lw_end got rw=%0d instret=%0d req=%b adr=%b imm=%b want 1/1/1/0/00",
        rw_cnt, bus.instret, bus.mem_req, bus.adr_src, bus.imm_src);
    end
  endtask

  // sw without stalls, then with 2 MEMWRITE waits.
  task automatic test_sw();
    logic [5:0] rdy;
    int mw_cnt, rw_cnt;
    do_reset();
    bus.op = OP_SW; bus.mem_ready = 1'b1; mw_cnt = 0; rw_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.mem_write) mw_cnt++;
      if (bus.reg_write) rw_cnt++;
      if (c == 3) begin
        checks++;
        if ({bus.mem_write, bus.adr_src, bus.mem_req} !== 3'b111) begin
          fails++; $display("FAIL sw_memwrite got %b want 111", {bus.mem_write, bus.adr_src, bus.mem_req});
        end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (mw_cnt != 1 || rw_cnt != 0 || bus.instret !== 32'd1 || bus.imm_src !== 2'b01) begin
      fails++; $display("FAIL sw_summary got mw=%0d rw=%0d instret=%0d imm=%b want 1/0/1/01",
        mw_cnt, rw_cnt, bus.instret, bus.imm_src);
    end
    rdy = 6'b111001; mw_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      bus.mem_ready = rdy[5-c];
      #1;
      if (bus.mem_write && bus.adr_src) mw_cnt++;
      @(negedge clk);
    end
    bus.mem_ready = 1'b1; #1;
    checks++;
    if (mw_cnt != 3 || bus.instret !== 32'd2 || bus.mem_req !== 1'b1 || bus.adr_src !== 1'b0) begin
      fails++; $display("FAIL sw_stall got mw=%0d instret=%0d req=%b adr=%b want 3/2/1/0",
        mw_cnt, bus.instret, bus.mem_req, bus.adr_src);
    end
  endtask

  // beq taken then not taken; zero held for the whole instruction.
  task automatic test_beq();
    logic [2:0] pw;
    do_reset();
    bus.op = OP_BEQ; bus.mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.zero = (k == 0);
      for (int c = 0; c < 3; c++) begin
        #1; pw[2-c] = bus.pc_write;
        @(negedge clk);
      end
      checks++;
      if (pw !== {2'b10, (k == 0)} || bus.imm_src !== 2'b10) begin
        fails++; $display("FAIL beq_zero%0d got pc_write=%b imm=%b want %b/10", k == 0, pw, bus.imm_src,
          {2'b10, (k == 0)});
      end
    end
    #1;
    checks++;
    if (bus.instret !== 32'd2 || bus.mem_req !== 1'b1) begin
      fails++; $display("FAIL beq_retire got instret=%0d req=%b want 2/1", bus.instret, bus.mem_req);
    end
  endtask

  // jal: PC loads in FETCH and JAL, link written in ALUWB.
  task automatic test_jal();
    logic [3:0] pw, rw;
    do_reset();
    bus.op = OP_JAL; bus.mem_ready = 1'b1; bus.zero = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1; pw[3-c] = bus.pc_write; rw[3-c] = bus.reg_write;
      @(negedge clk);
    end
    #1;
    checks++;
    if (pw !== 4'b1010 || rw !== 4'b0001 || bus.instret !== 32'd1 || bus.imm_src !== 2'b11) begin
      fails++; $display("FAIL jal got pw=%b rw=%b instret=%0d imm=%b want 1010/0001/1/11",
        pw, rw, bus.instret, bus.imm_src);
    end
  endtask

  // Reset during ALUWB drops the write and the retirement.
  task automatic test_reset_abort();
    do_reset();
    bus.op = OP_R; bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1; #1;
    checks++;
    if (bus.reg_write !== 1'b0) begin
      fails++; $display("FAIL abort_regwrite got %b want 0", bus.reg_write);
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (bus.instret !== 32'd0 || bus.mem_req !== 1'b1) begin
      fails++; $display("FAIL abort_state got instret=%0d req=%b want 0/1", bus.instret, bus.mem_req);
    end
  endtask

  // 17 R-type instructions: 4-bit counter wraps to 1.
  task automatic test_wrap();
    do_reset();
    bus.op = OP_R; bus.mem_ready = 1'b1;
    repeat (17 * 4) @(negedge clk);
    #1;
    checks++;
    if (bus4.instret !== 4'd1 || bus.instret !== 32'd17) begin
      fails++; $display("FAIL wrap got cnt4=%0d cnt32=%0d want 1/17", bus4.instret, bus.instret);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    bus.op = OP_BAD; bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
`ifdef CTRL_ILLEGAL_OP_EN
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.illegal_op !== 1'b1 || bus.mem_req !== 1'b0 || bus.ir_write !== 1'b0 || bus.pc_write !== 1'b0) begin
      fails++; $display("FAIL illegal_trap got ill=%b req=%b ir=%b pc=%b want 1/0/0/0",
        bus.illegal_op, bus.mem_req, bus.ir_write, bus.pc_write);
    end
    do_reset(); #1;
    checks++;
    if (bus.illegal_op !== 1'b0 || bus.mem_req !== 1'b1) begin
      fails++; $display("FAIL illegal_clear got ill=%b req=%b want 0/1", bus.illegal_op, bus.mem_req);
    end
`else
    checks++;
    if (bus.mem_req !== 1'b1 || bus.ir_write !== 1'b1 || bus.instret !== 32'd0 || bus.illegal_op !== 1'b0) begin
      fails++; $display("FAIL illegal_noop got req=%b ir=%b instret=%0d ill=%b want 1/1/0/0",
        bus.mem_req, bus.ir_write, bus.instret, bus.illegal_op);
    end
`endif
  endtask

  initial begin
    bus.op = OP_R; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw();
    test_beq();
    test_jal();
    test_reset_abort();
    test_wrap();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
